// File: rtl/aurora_rx_checker.sv
// -----------------------------------------------------------------------------
// aurora_rx_checker
//
// Sink stage for the Aurora 8b10b streaming RX interface. Checks the
// incrementing 16-bit counter pattern produced by the paired TX generator,
// tracks pattern lock and keeps a saturating bad-word count for LEDs/VIO.
//
// Handshake: the streaming RX has no back-pressure. A word is accepted on
// every USER_CLK edge where RX_SRC_RDY_N = 0 and CHANNEL_UP = 1; there is no
// ready signal. All outputs are registered and reflect the word accepted on
// the previous edge.
//
// Ports:
//   USER_CLK      in   Aurora user clock, the only clock
//   RESET_N       in   asynchronous active-low reset
//   CHANNEL_UP    in   channel-up status (USER_CLK domain)
//   RX_D          in   received word, lane k = RX_D[16k:16k+15], lane 0 at bit 0
//   RX_SRC_RDY_N  in   active-low valid for RX_D
//   CLR_ERR       in   one-cycle synchronous clear of ERR_COUNT
//   LOCKED        out  high while the checker is in LOCK
//   ERR_PULSE     out  one-cycle pulse per bad word seen in LOCK
//   ERR_COUNT     out  saturating bad-word count
//   LANE_ERR      out  per-lane mismatch flags of the last word checked in LOCK
//   GOOD_WORDS    out  matching-word count, wraps modulo 2^32
//   STATE_DBG     out  current FSM state (0 DOWN, 1 HUNT, 2 LOCK)
// -----------------------------------------------------------------------------
module aurora_rx_checker #(
    parameter int DATA_WIDTH = 48,
    parameter int LOCK_LOSS  = 4
) (
    input  logic                        USER_CLK,
    input  logic                        RESET_N,
    input  logic                        CHANNEL_UP,
    input  logic [0:DATA_WIDTH-1]       RX_D,
    input  logic                        RX_SRC_RDY_N,
    input  logic                        CLR_ERR,
    output logic                        LOCKED,
    output logic                        ERR_PULSE,
    output logic [0:7]                  ERR_COUNT,
    output logic [0:DATA_WIDTH/16-1]    LANE_ERR,
    output logic [31:0]                 GOOD_WORDS,
    output logic [1:0]                  STATE_DBG
);

    localparam int LANES = DATA_WIDTH / 16;

    localparam logic [1:0] ST_DOWN = 2'd0;
    localparam logic [1:0] ST_HUNT = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              locked_q,     locked_d;
    logic              err_pulse_q,  err_pulse_d;
    logic [7:0]        err_count_q,  err_count_d;
    logic [0:LANES-1]  lane_err_q,   lane_err_d;
    logic [31:0]       good_words_q, good_words_d;
    logic [15:0]       expected_q,   expected_d;
    logic [3:0]        bad_run_q,    bad_run_d;

    // Descending copy of the word so lane slicing is plain arithmetic:
    // RX_D[0] (lane 0 MSB) lands at rx_word[DATA_WIDTH-1].
    logic [DATA_WIDTH-1:0] rx_word;
    assign rx_word = RX_D;

    logic [15:0]      rx_lane [LANES];
    logic             word_valid;
    logic             self_consistent;
    logic [0:LANES-1] lane_mismatch;
    logic             err_event;

    assign word_valid = !RX_SRC_RDY_N && CHANNEL_UP;

    always_comb begin
        self_consistent = 1'b1;
        lane_mismatch   = '0;
        for (int k = 0; k < LANES; k++) begin
            rx_lane[k] = rx_word[DATA_WIDTH-1-16*k -: 16];
        end
        for (int k = 0; k < LANES; k++) begin
            if (rx_lane[k] != rx_lane[0] + 16'(k)) begin
                self_consistent = 1'b0;
            end
            lane_mismatch[k] = (rx_lane[k] != expected_q + 16'(k));
        end
    end

    always_comb begin
        state_d      = state_q;
        err_pulse_d  = 1'b0;
        lane_err_d   = lane_err_q;
        good_words_d = good_words_q;
        expected_d   = expected_q;
        bad_run_d    = bad_run_q;
        err_event    = 1'b0;

        if (!CHANNEL_UP) begin
            state_d    = ST_DOWN;
            bad_run_d  = '0;
            lane_err_d = '0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    // The first channel-up cycle only arms the hunt; any word
                    // presented on it is ignored.
                    state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (word_valid && self_consistent) begin
                        expected_d   = rx_lane[0] + 16'(LANES);
                        bad_run_d    = '0;
                        good_words_d = good_words_q + 32'd1;
                        state_d      = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (word_valid) begin
                        // Expected advances on every word, good or bad, so a
                        // single corrupted word does not desynchronise us.
                        expected_d = expected_q + 16'(LANES);
                        if (lane_mismatch == '0) begin
                            bad_run_d    = '0;
                            good_words_d = good_words_q + 32'd1;
                            lane_err_d   = '0;
                        end else begin
                            err_event   = 1'b1;
                            err_pulse_d = 1'b1;
                            lane_err_d  = lane_mismatch;
                            bad_run_d   = bad_run_q + 4'd1;
                            if (bad_run_q + 4'd1 >= 4'(LOCK_LOSS)) begin
                                state_d = ST_HUNT;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_DOWN;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    // Clear has priority over a coincident error; the pulse still fires.
    always_comb begin
        err_count_d = err_count_q;
        if (err_event && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
        if (CLR_ERR) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_DOWN;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            lane_err_q   <= '0;
            good_words_q <= '0;
            expected_q   <= '0;
            bad_run_q    <= '0;
        end else begin
            state_q      <= state_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            lane_err_q   <= lane_err_d;
            good_words_q <= good_words_d;
            expected_q   <= expected_d;
            bad_run_q    <= bad_run_d;
        end
    end

    assign LOCKED     = locked_q;
    assign ERR_PULSE  = err_pulse_q;
    assign ERR_COUNT  = err_count_q;
    assign LANE_ERR   = lane_err_q;
    assign GOOD_WORDS = good_words_q;
    assign STATE_DBG  = state_q;

endmodule

// File: doc/aurora_rx_checker.md
Name: aurora_rx_checker

Overview:
- Sink stage directly downstream of the Aurora 8b10b streaming RX interface: consumes RX_D / RX_SRC_RDY_N on USER_CLK.
- Verifies the incrementing 16-bit counter pattern sent by the paired TX generator, tracks pattern lock, and produces a saturating error count for LEDs/VIO.
- The Aurora streaming RX has no back-pressure, so the block accepts a word on every cycle that RX_SRC_RDY_N is low.

Parameters:
- DATA_WIDTH, 48, RX word width; must be a multiple of 16. LANES = DATA_WIDTH/16 (3 by default).
- LOCK_LOSS, 4, consecutive bad words in LOCK that force a return to HUNT; legal range 1..15.

Ports:
- USER_CLK  in  1  Aurora user clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CHANNEL_UP  in  1  Aurora channel-up status, synchronous to USER_CLK.
- RX_D  in  [0:DATA_WIDTH-1]  received word; lane k = RX_D[16k:16k+15], lane 0 at bit 0 (MSB side).
- RX_SRC_RDY_N  in  1  active-low valid for RX_D.
- CLR_ERR  in  1  synchronous one-cycle clear of ERR_COUNT.
- LOCKED  out  1  high while state is LOCK.
- ERR_PULSE  out  1  one-cycle pulse per bad word detected in LOCK.
- ERR_COUNT  out  [0:7]  saturating bad-word count.
- LANE_ERR  out  LANES  per-lane mismatch flags of the last word checked in LOCK.
- GOOD_WORDS  out  32  count of matching words, wraps modulo 2^32.

Behaviour:
- Reset: asserting RESET_N low asynchronously forces state DOWN and clears LOCKED, ERR_PULSE, ERR_COUNT, LANE_ERR, GOOD_WORDS, the expected value and the bad-run counter to 0. Deassertion takes effect on the next USER_CLK edge.
- A valid word is any cycle with RX_SRC_RDY_N = 0 and CHANNEL_UP = 1. All outputs are registered. Check latency is 1 cycle: ERR_PULSE, LANE_ERR and GOOD_WORDS update on the edge after the valid word.
- Pattern definition: a word is self-consistent when lane k == lane0 + k (mod 2^16) for every k. The next expected lane0 is the current lane0 + LANES (mod 2^16).
- State DOWN:
  - LOCKED = 0; words are ignored.
  - Moves to HUNT on the first cycle CHANNEL_UP = 1.
- State HUNT:
  - A self-consistent valid word sets expected = lane0 + LANES, clears the bad-run counter, increments GOOD_WORDS and moves to LOCK.
  - An inconsistent word keeps the state in HUNT and is never counted as an error.
- State LOCK:
  - Each valid word is compared lane by lane against expected + k, and expected always advances by LANES.
  - Match: bad-run cleared, GOOD_WORDS incremented, LANE_ERR = 0.
  - Mismatch: ERR_PULSE = 1 for one cycle, ERR_COUNT incremented (saturating at 255), LANE_ERR[k] = 1 for each mismatching lane, bad-run incremented.
  - When bad-run reaches LOCK_LOSS, the state moves to HUNT and LOCKED = 0 on the same edge that registers that error.
- Any state: CHANNEL_UP = 0 moves to DOWN on the next edge and clears bad-run and LANE_ERR. ERR_COUNT and GOOD_WORDS are retained.
- Idle cycles (RX_SRC_RDY_N = 1) change nothing except ERR_PULSE, which returns to 0. LANE_ERR holds its value.
- CLR_ERR = 1 sets ERR_COUNT to 0 on the next edge. If an error occurs on the same edge, the clear wins (ERR_COUNT = 0), but ERR_PULSE still fires.
- Wrap-around: with LANES = 3, lane0 = 0xFFFE gives lanes FFFE, FFFF, 0000, and the next expected lane0 is 0x0001. No error at the wrap.

Test Plan:
- Reset and lock: RESET_N low, then high with CHANNEL_UP = 1; send {0x0010, 0x0011, 0x0012} followed by {0x0013, 0x0014, 0x0015}. Required: LOCKED = 1 one cycle after the first word; GOOD_WORDS = 2; ERR_COUNT = 0.
- Single lane error: in LOCK, send {0x0016, 0x0017, 0x0000} in place of {0x0016, 0x0017, 0x0018}, then resume at 0x0019. Required: one ERR_PULSE; LANE_ERR = 3'b001 (lane 2 only); ERR_COUNT = 1; LOCKED stays 1; the following word passes.
- Loss of lock: in LOCK, send 4 consecutive words of all-zero lanes. Required: ERR_COUNT = 4; LOCKED = 0 on the edge after the 4th word. A following self-consistent word {0x1000, 0x1001, 0x1002} relocks with no further error.
- Wrap and idle gaps: lock at 0xFFF8 and stream across 0xFFFE/0xFFFF/0x0000, with RX_SRC_RDY_N = 1 for 3 cycles between words. Required: zero errors and GOOD_WORDS incremented once per valid word only.
- Saturation and clear: force 300 bad words while relocking as needed. Required: ERR_COUNT = 255. Then assert CLR_ERR on the same cycle as an error. Required: ERR_COUNT = 0 and ERR_PULSE = 1.
- Channel drop and async reset: drop CHANNEL_UP mid-lock. Required: LOCKED = 0 next cycle, ERR_COUNT retained, HUNT entered when CHANNEL_UP returns. Then pulse RESET_N low between clock edges. Required: all outputs 0 immediately, without waiting for a clock edge.
